// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one synchronous memory between the CPU bus and a host loader/debug port.
// One memory command per cycle; host bursts are bounded so the CPU cannot be starved.
module mem_arbiter #(
  parameter int AWIDTH    = 5,
  parameter int DWIDTH    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [AWIDTH-1:0] cpu_addr,
  input  logic [DWIDTH-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DWIDTH-1:0] cpu_rdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [AWIDTH-1:0] host_addr,
  input  logic [DWIDTH-1:0] host_wdata,
  input  logic              host_lock,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DWIDTH-1:0] host_rdata,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_wdata,
  input  logic [DWIDTH-1:0] mem_rdata
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] BURST_MAX = CW'(MAX_BURST);

  typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_HOST} owner_t;
  typedef enum logic {LAST_CPU, LAST_HOST} last_t;

  owner_t            owner_q, owner_d;
  last_t             last_owner_q, last_owner_d;
  logic [CW-1:0]     burst_cnt_q, burst_cnt_d;
  logic              cpu_gnt_q, cpu_gnt_d;
  logic              host_gnt_q, host_gnt_d;
  logic              cpu_rvalid_q, cpu_rvalid_d;
  logic              host_rvalid_q, host_rvalid_d;
  logic              mem_rd_q, mem_rd_d;
  logic              mem_wr_q, mem_wr_d;
  logic [AWIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DWIDTH-1:0] mem_wdata_q, mem_wdata_d;

  logic cpu_elig;
  logic host_elig;

  // A port whose grant is on the bus this cycle is still holding the same request.
  assign cpu_elig  = cpu_req  && !cpu_gnt_q;
  assign host_elig = host_req && !host_gnt_q;

  always_comb begin
    owner_d       = OWN_NONE;
    last_owner_d  = last_owner_q;
    burst_cnt_d   = burst_cnt_q;
    cpu_gnt_d     = 1'b0;
    host_gnt_d    = 1'b0;
    mem_rd_d      = 1'b0;
    mem_wr_d      = 1'b0;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    cpu_rvalid_d  = mem_rd_q && (owner_q == OWN_CPU);
    host_rvalid_d = mem_rd_q && (owner_q == OWN_HOST);

    if (cpu_elig && host_elig) begin
      if (host_lock && (last_owner_q == LAST_HOST) && (burst_cnt_q < BURST_MAX)) begin
        owner_d = OWN_HOST;
      end else if (last_owner_q == LAST_HOST) begin
        owner_d = OWN_CPU;
      end else begin
        owner_d = OWN_HOST;
      end
    end else if (cpu_elig) begin
      owner_d = OWN_CPU;
    end else if (host_elig) begin
      owner_d = OWN_HOST;
    end

    case (owner_d)
      OWN_CPU: begin
        cpu_gnt_d    = 1'b1;
        mem_rd_d     = !cpu_we;
        mem_wr_d     = cpu_we;
        mem_addr_d   = cpu_addr;
        mem_wdata_d  = cpu_wdata;
        last_owner_d = LAST_CPU;
      end
      OWN_HOST: begin
        host_gnt_d   = 1'b1;
        mem_rd_d     = !host_we;
        mem_wr_d     = host_we;
        mem_addr_d   = host_addr;
        mem_wdata_d  = host_wdata;
        last_owner_d = LAST_HOST;
      end
      default: ;
    endcase

    // Burst counts only locked host grants; any CPU grant or released lock restarts it.
    if ((owner_d == OWN_CPU) || !host_lock) begin
      burst_cnt_d = '0;
    end else if ((owner_d == OWN_HOST) && (burst_cnt_q != BURST_MAX)) begin
      burst_cnt_d = burst_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_q       <= OWN_NONE;
      last_owner_q  <= LAST_HOST;
      burst_cnt_q   <= '0;
      cpu_gnt_q     <= 1'b0;
      host_gnt_q    <= 1'b0;
      cpu_rvalid_q  <= 1'b0;
      host_rvalid_q <= 1'b0;
      mem_rd_q      <= 1'b0;
      mem_wr_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
    end else begin
      owner_q       <= owner_d;
      last_owner_q  <= last_owner_d;
      burst_cnt_q   <= burst_cnt_d;
      cpu_gnt_q     <= cpu_gnt_d;
      host_gnt_q    <= host_gnt_d;
      cpu_rvalid_q  <= cpu_rvalid_d;
      host_rvalid_q <= host_rvalid_d;
      mem_rd_q      <= mem_rd_d;
      mem_wr_q      <= mem_wr_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
    end
  end

  assign cpu_gnt     = cpu_gnt_q;
  assign host_gnt    = host_gnt_q;
  assign cpu_rvalid  = cpu_rvalid_q;
  assign host_rvalid = host_rvalid_q;
  assign mem_rd      = mem_rd_q;
  assign mem_wr      = mem_wr_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign cpu_rdata   = mem_rdata;
  assign host_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a synchronous memory model behind the bus.
module tb_mem_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       cpu_req, cpu_we, host_req, host_we, host_lock;
  logic [4:0] cpu_addr, host_addr;
  logic [7:0] cpu_wdata, host_wdata;
  logic       cpu_gnt, cpu_rvalid, host_gnt, host_rvalid;
  logic [7:0] cpu_rdata, host_rdata;
  logic       mem_rd, mem_wr;
  logic [4:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata = 8'h00;
  logic [7:0] mem [32];

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.AWIDTH(5), .DWIDTH(8), .MAX_BURST(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_lock(host_lock), .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always @(posedge clk) begin
    if (mem_wr) mem[mem_addr] <= mem_wdata;
    if (mem_rd) mem_rdata <= mem[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"}, {30'd0, cpu_gnt, host_gnt}, 32'd0);
    check({tag, "_rvalid"}, {30'd0, cpu_rvalid, host_rvalid}, 32'd0);
    check({tag, "_memcmd"}, {30'd0, mem_rd, mem_wr}, 32'd0);
    check({tag, "_addr"}, {27'd0, mem_addr}, 32'd0);
    check({tag, "_wdata"}, {24'd0, mem_wdata}, 32'd0);
  endtask

  initial begin
    int host_run;
    logic prev_cpu, prev_host;
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    mem[5] = 8'hA3;
    reset = 1'b0;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    host_req = 0; host_we = 0; host_addr = 0; host_wdata = 0; host_lock = 0;
    tick();
    tick();
    check_all_zero("reset");
    reset = 1'b1;
    tick();
    $display("reset released");

    // CPU read of address 5
    cpu_req = 1; cpu_we = 0; cpu_addr = 5'd5;
    tick();
    check("cpu_rd_gnt", {31'd0, cpu_gnt}, 32'd1);
    check("cpu_rd_memrd", {30'd0, mem_rd, mem_wr}, 32'd2);
    check("cpu_rd_addr", {27'd0, mem_addr}, 32'd5);
    check("cpu_rd_no_host", {31'd0, host_gnt}, 32'd0);
    tick();
    check("cpu_rd_no_regrant", {31'd0, cpu_gnt}, 32'd0);
    check("cpu_rd_rvalid", {31'd0, cpu_rvalid}, 32'd1);
    check("cpu_rd_rdata", {24'd0, cpu_rdata}, 32'hA3);
    check("cpu_rd_no_host_rvalid", {31'd0, host_rvalid}, 32'd0);
    $display("txn cpu read addr 5 data %h", cpu_rdata);
    cpu_req = 0;
    tick();

    // Host write of 5C to address 3
    host_req = 1; host_we = 1; host_addr = 5'd3; host_wdata = 8'h5C;
    tick();
    check("host_wr_gnt", {31'd0, host_gnt}, 32'd1);
    check("host_wr_memwr", {30'd0, mem_rd, mem_wr}, 32'd1);
    check("host_wr_addr", {27'd0, mem_addr}, 32'd3);
    check("host_wr_wdata", {24'd0, mem_wdata}, 32'h5C);
    check("host_wr_no_cpu", {31'd0, cpu_gnt}, 32'd0);
    tick();
    check("host_wr_no_regrant", {31'd0, host_gnt}, 32'd0);
    check("host_wr_no_rvalid", {31'd0, host_rvalid}, 32'd0);
    check("host_wr_mem", {24'd0, mem[3]}, 32'h5C);
    $display("txn host write addr 3 data 5c");
    host_req = 0;
    tick();
    check("host_wr_idle", {31'd0, host_gnt}, 32'd0);

    // Both continuous reads, no lock: C,H,C,H with CPU first (last owner is host)
    cpu_req = 1; cpu_we = 0; cpu_addr = 5'd5;
    host_req = 1; host_we = 0; host_addr = 5'd3;
    tick();
    check("rr0_cpu", {30'd0, cpu_gnt, host_gnt}, 32'd2);
    tick();
    check("rr1_host", {30'd0, cpu_gnt, host_gnt}, 32'd1);
    check("rr1_cpu_rdata", {23'd0, cpu_rvalid, cpu_rdata}, 32'h1A3);
    tick();
    check("rr2_cpu", {30'd0, cpu_gnt, host_gnt}, 32'd2);
    check("rr2_host_rdata", {23'd0, host_rvalid, host_rdata}, 32'h15C);
    tick();
    check("rr3_host", {30'd0, cpu_gnt, host_gnt}, 32'd1);
    $display("txn round robin C,H,C,H");
    cpu_req = 0; host_req = 0;
    tick();
    check("rr_tail_host_rvalid", {31'd0, host_rvalid}, 32'd1);
    tick();

    // Locked burst with both requesting: host wins the first tie, then strict alternation
    host_lock = 1;
    cpu_req = 1; host_req = 1;
    host_run = 0; prev_cpu = 0; prev_host = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      check($sformatf("lock%0d_host", i), {31'd0, host_gnt}, {31'd0, (i % 2 == 0)});
      check($sformatf("lock%0d_cpu", i), {31'd0, cpu_gnt}, {31'd0, (i % 2 == 1)});
      check($sformatf("lock%0d_b2b", i), {30'd0, cpu_gnt & prev_cpu, host_gnt & prev_host}, 32'd0);
      if (cpu_gnt) host_run = 0;
      if (host_gnt) host_run++;
      check($sformatf("lock%0d_run_le4", i), {31'd0, host_run > 4}, 32'd0);
      prev_cpu = cpu_gnt; prev_host = host_gnt;
      $display("txn lock cycle %0d cpu_gnt %0d host_gnt %0d", i, cpu_gnt, host_gnt);
    end
    cpu_req = 0; host_req = 0;
    tick();
    tick();

    // CPU idle, host locked for 10 writes: none blocked by burst saturation
    host_req = 1; host_we = 1;
    for (int i = 0; i < 10; i++) begin
      host_addr = 5'(8 + i); host_wdata = 8'(8'h10 + i);
      tick();
      check($sformatf("burst%0d_gnt", i), {31'd0, host_gnt}, 32'd1);
      check($sformatf("burst%0d_addr", i), {27'd0, mem_addr}, 32'(8 + i));
      tick();
      check($sformatf("burst%0d_gap", i), {31'd0, host_gnt}, 32'd0);
      $display("txn host burst write %0d addr %0d", i, 8 + i);
    end
    host_req = 0; host_we = 0;
    tick();
    check("burst_mem_first", {24'd0, mem[8]}, 32'h10);
    check("burst_mem_last", {24'd0, mem[17]}, 32'h19);

    // Reset during a CPU read command: dropped immediately, no rvalid, CPU wins next tie
    host_lock = 0;
    cpu_req = 1; cpu_we = 0; cpu_addr = 5'd5;
    tick();
    check("rst_pre_gnt", {30'd0, cpu_gnt, mem_rd}, 32'd3);
    reset = 1'b0;
    cpu_req = 0;
    #1;
    check_all_zero("rst_async");
    tick();
    check("rst_no_rvalid", {31'd0, cpu_rvalid}, 32'd0);
    tick();
    reset = 1'b1;
    cpu_req = 1; host_req = 1; host_we = 0; host_addr = 5'd3;
    tick();
    check("rst_tie_cpu", {30'd0, cpu_gnt, host_gnt}, 32'd2);
    check("rst_tie_no_rvalid", {31'd0, cpu_rvalid}, 32'd0);
    $display("txn post-reset tie cpu_gnt %0d host_gnt %0d", cpu_gnt, host_gnt);
    cpu_req = 0; host_req = 0;
    tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
